booth_core: RTL and testbench
=============================

Name: booth_core

Overview:
- Sequential radix-2 Booth multiplier control and datapath stage that sits directly downstream of the multiplicand register.
- Commands the multiplicand register load through CargaM and consumes its registered output on M.
- Holds the multiplier, the accumulator and the Booth guard bit internally.
- Produces a signed 2N-bit product with a one-cycle Done strobe.

Parameters:
- N, 4, operand width in bits; the multiplicand and multiplier are N-bit two's complement.
- CW, 3, width of the iteration counter; must satisfy 2^CW > N.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset; Reset=0 forces reset state immediately.
- Start  input  1  request a multiply; sampled in IDLE (see Optional Feature for other states).
- Q_in  input  N  multiplier operand; captured during the LOAD cycle.
- M  input  N  multiplicand, taken from the multiplicand register output.
- CargaM  output  1  load enable to the multiplicand register; high only in LOAD.
- Busy  output  1  high in LOAD and OP.
- Done  output  1  high for exactly one cycle when the product is valid.
- Producto  output  2N  signed product; holds its value until the next LOAD.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE; A=0 (N+1 bits); Q=0; q_1=0; count=0.
  - Producto=0; CargaM=0; Busy=0; Done=0.
  - Applies at any time, including mid-operation; the operation is abandoned and there is no Done.
- FSM states: IDLE, LOAD, OP, DONE.
- IDLE:
  - Start=1 at an edge -> LOAD; otherwise stay in IDLE.
  - Outputs low; Producto holds.
- LOAD (exactly one cycle):
  - CargaM=1, so the multiplicand register captures its input on this edge.
  - Q<=Q_in; A<=0; q_1<=0; count<=N.
  - Producto<=0.
  - Next state: OP.
- OP (exactly N cycles):
  - M is stable from the multiplicand register from the first OP cycle onward.
  - Each cycle, {Q[0],q_1} selects the Booth operation:
    - 01: A+sext(M)
    - 10: A-sext(M)
    - 00 or 11: A unchanged
  - The selected result is arithmetic-shifted right one place across {A,Q,q_1}, all in the same cycle.
  - count<=count-1.
  - When count==1 at the edge, the state moves to DONE.
- Width rule: A is N+1 bits with M sign-extended to N+1 bits, so -2^(N-1) as a multiplicand does not overflow. Producto = the low 2N bits of {A,Q} after the final shift.
- DONE (one cycle):
  - Done=1.
  - Producto is loaded with the result on the edge entering DONE and is valid while Done=1.
  - Next state: IDLE unconditionally. A Start in DONE is ignored.
- Latency:
  - Done is high in the cycle following the (N+1)th edge after the edge that sampled Start.
  - N=4: Start sampled at edge 0; Done high after edge 5.
  - Back-to-back throughput is one product per N+3 cycles.
- Start held high continuously: a new multiply begins each time the FSM returns to IDLE.
- Q_in is don't-care outside the LOAD cycle. M changes outside LOAD are not expected, because CargaM is only asserted in LOAD.

Optional Feature:
- Macro: BOOTH_RESTART_EN.
- Defined:
  - Start=1 at an edge while in OP forces state<=LOAD. The current operation is abandoned; Producto is not updated and no Done is issued for it.
  - The restart then follows the normal LOAD/OP/DONE sequence with fresh operands.
- Undefined: Start is ignored in LOAD, OP and DONE.

Test Plan:
- Reset low, then high; Start with M-source=3, Q_in=5 (N=4) -> CargaM high one cycle, Busy for 5 cycles, Done one cycle with Producto=8'h0F.
- Start with M=-3 (4'hD), Q_in=5 -> Producto=8'hF1 (-15). Also M=7, Q_in=-8 (4'h8) -> 8'hC8 (-56).
- Start with M=-8 (4'h8), Q_in=-8 -> Producto=8'h40 (+64); checks the N+1-bit accumulator.
- Drop Reset to 0 during the second OP cycle, mid-multiply -> all outputs 0 immediately, state IDLE, no Done. After release, a new Start with M=2, Q_in=2 -> 8'h04.
- Pulse Start during the third OP cycle of M=3 × Q_in=3:
  - Macro defined: restart; Done appears only for the second operands.
  - Macro undefined: Done with 8'h09 at normal latency, then IDLE.
- Hold Start high for 20 cycles with M=1, Q_in=-1 -> Done every 7 cycles, Producto=8'hFF each time.

Source files
------------

// File: rtl/booth_core_if.sv
// ---------------------------------------------------------------------------
// booth_core_if
//
// Purpose: groups the command/result signals of the Booth multiplier stage so
// that the core and whatever drives it (a sequencer plus the multiplicand
// register) share one bundle.
//
// Handshake: Start is a request that the core samples only while idle. There
// is no ready signal. The requester sees the request accepted when Busy rises
// in the next cycle. The result is valid only in the cycle where Done=1, and
// there is no back-pressure on it. Producto keeps that value until the next
// operand load clears it.
//
// Signals:
//   Start    master->slave  request a multiply
//   Q_in     master->slave  multiplier operand, sampled during the load cycle
//   M        master->slave  multiplicand, from the multiplicand register
//   CargaM   slave->master  load enable for the multiplicand register
//   Busy     slave->master  operation in progress (load + iterate)
//   Done     slave->master  one-cycle product-valid strobe
//   Producto slave->master  signed 2N-bit product
// ---------------------------------------------------------------------------
interface booth_core_if #(
    parameter int N = 4
);
    logic             Start;
    logic [N-1:0]     Q_in;
    logic [N-1:0]     M;
    logic             CargaM;
    logic             Busy;
    logic             Done;
    logic [2*N-1:0]   Producto;

    modport master (
        output Start,
        output Q_in,
        output M,
        input  CargaM,
        input  Busy,
        input  Done,
        input  Producto
    );

    modport slave (
        input  Start,
        input  Q_in,
        input  M,
        output CargaM,
        output Busy,
        output Done,
        output Producto
    );
endinterface

// File: rtl/booth_core.sv
// ---------------------------------------------------------------------------
// booth_core
//
// Purpose: sequential radix-2 Booth multiplier control and datapath. The core
// sits downstream of an external multiplicand register. It pulses CargaM to
// load that register and then reads the registered multiplicand on M. The
// multiplier, the accumulator and the Booth guard bit are held here. The core
// produces a signed 2N-bit product with a one-cycle Done strobe.
//
// Parameters:
//   N   operand width (two's complement multiplicand and multiplier)
//   CW  iteration counter width, 2**CW must exceed N
//
// Ports:
//   clk        rising-edge clock
//   Reset      asynchronous, active-low reset
//   bus        booth_core_if.slave: Start, Q_in, M in; CargaM, Busy, Done,
//              Producto out
//   dbg_state  current FSM state (0 IDLE, 1 LOAD, 2 OP, 3 DONE)
//
// Build option:
//   BOOTH_RESTART_EN  when defined, Start seen during OP abandons the current
//                     multiply and restarts from LOAD with fresh operands.
//                     When undefined, Start is ignored outside IDLE.
// ---------------------------------------------------------------------------
module booth_core #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic         clk,
    input  logic         Reset,
    booth_core_if.slave  bus,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_OP   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // The accumulator is one bit wider than the operands. Without the extra
    // bit, A - sext(M) overflows when M = -2**(N-1).
    logic [N:0]       a;
    logic [N-1:0]     q;
    logic             q_1;
    logic [CW-1:0]    count;
    logic [2*N-1:0]   producto;

    logic [N:0]       m_ext;
    logic [N:0]       a_sum;
    logic [N:0]       a_sh;
    logic [N-1:0]     q_sh;
    logic             q_1_sh;
    logic             last_iter;
    logic             finish;

    // ---------------------------------------------------------------------
    // Booth step: add/subtract/keep, then arithmetic shift of {A,Q,q_1}
    // ---------------------------------------------------------------------
    always_comb begin
        m_ext = {bus.M[N-1], bus.M};
    end

    always_comb begin
        a_sum = a;
        unique case ({q[0], q_1})
            2'b01:   a_sum = a + m_ext;
            2'b10:   a_sum = a - m_ext;
            default: a_sum = a;
        endcase
    end

    // One arithmetic right shift across the concatenation {A, Q, q_1}.
    // The sign bit of A is replicated. The LSB of A enters the top of Q, and
    // the LSB of Q becomes the new guard bit.
    always_comb begin
        a_sh   = {a_sum[N], a_sum[N:1]};
        q_sh   = {a_sum[0], q[N-1:1]};
        q_1_sh = q[0];
    end

    assign last_iter = (count == CW'(1));

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (bus.Start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = S_OP;
            end
            S_OP: begin
`ifdef BOOTH_RESTART_EN
                // A restart request has priority over finishing. The
                // in-flight product is dropped without a Done.
                if (bus.Start) begin
                    state_nxt = S_LOAD;
                end else if (last_iter) begin
                    state_nxt = S_DONE;
                end
`else
                if (last_iter) begin
                    state_nxt = S_DONE;
                end
`endif
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The product is captured only on a real OP -> DONE transition. An
    // abandoned restart therefore never updates Producto.
    assign finish = (state == S_OP) && (state_nxt == S_DONE);

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            a        <= '0;
            q        <= '0;
            q_1      <= 1'b0;
            count    <= '0;
            producto <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    a        <= '0;
                    q        <= bus.Q_in;
                    q_1      <= 1'b0;
                    count    <= CW'(N);
                    producto <= '0;
                end
                S_OP: begin
                    a     <= a_sh;
                    q     <= q_sh;
                    q_1   <= q_1_sh;
                    count <= count - CW'(1);
                    if (finish) begin
                        // The low 2N bits of {A,Q} after the final shift.
                        producto <= {a_sh[N-1:0], q_sh};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs (decoded from state so reset clears them immediately)
    // ---------------------------------------------------------------------
    assign bus.CargaM   = (state == S_LOAD);
    assign bus.Busy     = (state == S_LOAD) || (state == S_OP);
    assign bus.Done     = (state == S_DONE);
    assign bus.Producto = producto;
    assign dbg_state    = state;

endmodule

// File: tb/tb_booth_core.sv
module tb_booth_core;
  localparam int N = 4;
  localparam int W = 2 * N;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] m_src;
  logic [N-1:0] m_reg;
  logic [1:0]   dbg_state;

  booth_core_if #(.N(N)) bus();

  // multiplicand register upstream of the core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reg <= '0;
    else if (bus.CargaM) m_reg <= m_src;
  end
  assign bus.M = m_reg;

  booth_core #(.N(N), .CW(3)) dut (
    .clk(clk),
    .Reset(rst_n),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_prod = '0;

  typedef struct {
    logic [N-1:0] m;
    logic [N-1:0] q;
    logic [W-1:0] prod;
  } vec_t;
  vec_t vecs[7];

  // reference: plain signed multiplication truncated to 2N bits
  function automatic logic [W-1:0] ref_mul(input logic [N-1:0] m, input logic [N-1:0] q);
    int a;
    int b;
    int p;
    a = $signed(m);
    b = $signed(q);
    p = a * b;
    return p[W-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // advance one cycle and sample at the falling edge; scoreboard on Done
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (rst_n && bus.Done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Producto=%0h, required no Done (t=%0t)", bus.Producto, $time);
      end else begin
        last_prod = exp_q.pop_front();
        check("producto", 32'(bus.Producto), 32'(last_prod));
      end
    end
  endtask

  // one full multiply with cycle-by-cycle control checks
  task automatic run_mul(input logic [N-1:0] m, input logic [N-1:0] q);
    m_src = m;
    bus.Q_in = q;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check("cargam_load", 32'(bus.CargaM), 1);
    check("busy_load", 32'(bus.Busy), 1);
    check("done_load", 32'(bus.Done), 0);
    tick();
    m_src = N'($urandom);
    bus.Q_in = N'($urandom);
    check("producto_cleared", 32'(bus.Producto), 0);
    for (int i = 0; i < N; i++) begin
      check("cargam_op", 32'(bus.CargaM), 0);
      check("busy_op", 32'(bus.Busy), 1);
      check("done_op", 32'(bus.Done), 0);
      tick();
    end
    check("done_high", 32'(bus.Done), 1);
    check("busy_done", 32'(bus.Busy), 0);
    tick();
    check("done_one_cycle", 32'(bus.Done), 0);
    check("idle_state", 32'(dbg_state), 0);
    check("producto_hold", 32'(bus.Producto), 32'(last_prod));
  endtask

  initial begin
    int d0;
    logic [N-1:0] rm;
    logic [N-1:0] rq;

    vecs[0] = '{m: 4'h3, q: 4'h5, prod: 8'h0F};
    vecs[1] = '{m: 4'hD, q: 4'h5, prod: 8'hF1};
    vecs[2] = '{m: 4'h7, q: 4'h8, prod: 8'hC8};
    vecs[3] = '{m: 4'h8, q: 4'h8, prod: 8'h40};
    vecs[4] = '{m: 4'h2, q: 4'h2, prod: 8'h04};
    vecs[5] = '{m: 4'h3, q: 4'h3, prod: 8'h09};
    vecs[6] = '{m: 4'h1, q: 4'hF, prod: 8'hFF};

    rst_n = 1'b0;
    bus.Start = 1'b0;
    bus.Q_in = '0;
    m_src = '0;
    tick();
    tick();
    check("rst_cargam", 32'(bus.CargaM), 0);
    check("rst_busy", 32'(bus.Busy), 0);
    check("rst_done", 32'(bus.Done), 0);
    check("rst_producto", 32'(bus.Producto), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    tick();

    // table-driven vectors
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(vecs[i].prod);
      run_mul(vecs[i].m, vecs[i].q);
    end

    // asynchronous reset during the second OP cycle
    d0 = done_cnt;
    m_src = 4'h3;
    bus.Q_in = 4'h5;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick();
    tick();
    check("pre_rst_busy", 32'(bus.Busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_cargam", 32'(bus.CargaM), 0);
    check("midrst_busy", 32'(bus.Busy), 0);
    check("midrst_done", 32'(bus.Done), 0);
    check("midrst_producto", 32'(bus.Producto), 0);
    check("midrst_state", 32'(dbg_state), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("midrst_no_done", 32'(done_cnt - d0), 0);
    exp_q.push_back(8'h04);
    run_mul(4'h2, 4'h2);

    // Start pulse during the third OP cycle of 3 x 3
    d0 = done_cnt;
    m_src = 4'h3;
    bus.Q_in = 4'h3;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick();
    tick();
    tick();
    check("restart_in_op", 32'(dbg_state), 2);
`ifdef BOOTH_RESTART_EN
    exp_q.push_back(ref_mul(4'h2, 4'hD));
`else
    exp_q.push_back(8'h09);
`endif
    m_src = 4'h2;
    bus.Q_in = 4'hD;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
`ifdef BOOTH_RESTART_EN
    check("restart_state", 32'(dbg_state), 1);
`else
    check("restart_state", 32'(dbg_state), 2);
`endif
    for (int i = 0; i < 10; i++) tick();
    check("restart_done_count", 32'(done_cnt - d0), 1);
    check("restart_idle", 32'(dbg_state), 0);

    // Start held high: Done every N+3 cycles
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) exp_q.push_back(ref_mul(4'h1, 4'hF));
    m_src = 4'h1;
    bus.Q_in = 4'hF;
    bus.Start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("held_done", 32'(bus.Done), (i == 6 || i == 13 || i == 20) ? 1 : 0);
    end
    bus.Start = 1'b0;
    tick();
    tick();
    check("held_done_count", 32'(done_cnt - d0), 3);
    check("held_idle", 32'(dbg_state), 0);

    // randomized operands against the reference model
    for (int i = 0; i < 20; i++) begin
      rm = N'($urandom_range(15, 0));
      rq = N'($urandom_range(15, 0));
      exp_q.push_back(ref_mul(rm, rq));
      run_mul(rm, rq);
    end

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
